// File: rtl/round_sat.sv
// Round-half-up then saturate: two-stage valid/ready pipeline with a sticky
// overflow flag and a saturating count of clipped output transfers.
module round_sat #(
  parameter int unsigned IW    = 17,
  parameter int unsigned SHIFT = 1,
  parameter int unsigned OW    = 16,
  parameter int unsigned CW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [IW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [OW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sat,
  output logic          ovf,
  output logic [CW-1:0] sat_cnt,
  input  logic          clr_ovf
);

  // One guard bit so the rounding add can never wrap.
  localparam int unsigned RW = IW + 1;

  localparam logic signed [RW-1:0] MaxVal = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [RW-1:0] MinVal = {{(RW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic signed [RW-1:0] in_ext;
  logic signed [RW-1:0] rnd;

  logic                 s1_valid_q;
  logic signed [RW-1:0] s1_data_q;
  logic                 out_valid_q;
  logic [OW-1:0]        out_data_q;
  logic                 out_sat_q;
  logic                 ovf_q, ovf_d;
  logic [CW-1:0]        sat_cnt_q, sat_cnt_d;

  logic                 stall;
  logic                 sat_hi, sat_lo;
  logic [OW-1:0]        sat_data;
  logic                 sat_xfer;

  assign in_ext = {in_data[IW-1], in_data};

  if (SHIFT == 0) begin : g_no_round
    assign rnd = in_ext;
  end else begin : g_round
    logic signed [RW-1:0] sum;
    assign sum = in_ext + (RW'(1) << (SHIFT - 1));
    assign rnd = sum >>> SHIFT;
  end

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = en & ~stall;
  assign sat_xfer = out_valid_q & out_ready & out_sat_q;

  always_comb begin
    sat_hi   = s1_data_q > MaxVal;
    sat_lo   = s1_data_q < MinVal;
    sat_data = s1_data_q[OW-1:0];
    if (sat_hi) begin
      sat_data = {1'b0, {(OW-1){1'b1}}};
    end else if (sat_lo) begin
      sat_data = {1'b1, {(OW-1){1'b0}}};
    end
  end

  // A saturated transfer in the same cycle as a clear still counts once.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    ovf_d     = ovf_q;
    if (sat_xfer) begin
      ovf_d = 1'b1;
      if (clr_ovf) begin
        sat_cnt_d = CW'(1);
      end else if (!(&sat_cnt_q)) begin
        sat_cnt_d = sat_cnt_q + CW'(1);
      end
    end else if (clr_ovf) begin
      ovf_d     = 1'b0;
      sat_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      ovf_q       <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      ovf_q     <= ovf_d;
      sat_cnt_q <= sat_cnt_d;
      if (!en) begin
        s1_valid_q  <= 1'b0;
        out_valid_q <= 1'b0;
      end else if (!stall) begin
        s1_valid_q  <= in_valid;
        out_valid_q <= s1_valid_q;
        if (in_valid) begin
          s1_data_q <= rnd;
        end
        // Output data only moves with a real sample so it holds across bubbles.
        if (s1_valid_q) begin
          out_data_q <= sat_data;
          out_sat_q  <= sat_hi | sat_lo;
        end
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sat   = out_sat_q;
  assign ovf       = ovf_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_round_sat.sv
// Bench for round_sat: arithmetic reference model checked every cycle on the
// default instance, plus directed literal cases on a SHIFT=0, CW=2 instance.
module tb_round_sat;

  localparam int unsigned IW = 17;
  localparam int unsigned SH = 1;
  localparam int unsigned OW = 16;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          en, in_valid, in_ready, out_valid, out_ready, out_sat, ovf, clr_ovf;
  logic [IW-1:0] in_data;
  logic [OW-1:0] out_data;
  logic [CW-1:0] sat_cnt;

  logic          en1, in_valid1, in_ready1, out_valid1, out_ready1, out_sat1, ovf1, clr1;
  logic [IW-1:0] in_data1;
  logic [OW-1:0] out_data1;
  logic [1:0]    sat_cnt1;

  round_sat #(.IW(IW), .SHIFT(SH), .OW(OW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sat(out_sat), .ovf(ovf), .sat_cnt(sat_cnt), .clr_ovf(clr_ovf)
  );

  round_sat #(.IW(17), .SHIFT(0), .OW(16), .CW(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_sat(out_sat1), .ovf(ovf1), .sat_cnt(sat_cnt1),
    .clr_ovf(clr1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint round_ref(input longint x, input int sh);
    if (sh == 0) return x;
    return (x + (longint'(1) << (sh - 1))) >>> sh;
  endfunction

  function automatic longint clip_ref(input longint r, input int ow);
    longint hi = (longint'(1) << (ow - 1)) - 1;
    longint lo = -hi - 1;
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

  // Reference model: two pipeline slots holding raw inputs; output value derived
  // arithmetically only when a sample reaches the output slot.
  bit     m_s1v, m_s2v, m_sat, m_ovf;
  longint m_s1x, m_last, m_cnt;
  longint cnt_max = (longint'(1) << CW) - 1;

  always @(negedge clk) begin
    bit     stall, itr;
    longint r;
    if (!rst_n) begin
      m_s1v = 0; m_s2v = 0; m_sat = 0; m_ovf = 0; m_s1x = 0; m_last = 0; m_cnt = 0;
    end
    chk("out_valid", out_valid, m_s2v);
    chk("out_data", $signed(out_data), m_last);
    chk("out_sat", out_sat, m_sat);
    chk("ovf", ovf, m_ovf);
    chk("sat_cnt", sat_cnt, m_cnt);
    chk("in_ready", in_ready, en && !(m_s2v && !out_ready));
    if (rst_n) begin
      stall = m_s2v && !out_ready;
      itr   = in_valid && en && !stall;
      if (m_s2v && out_ready && m_sat) begin
        m_ovf = 1;
        m_cnt = clr_ovf ? 1 : (m_cnt < cnt_max ? m_cnt + 1 : m_cnt);
      end else if (clr_ovf) begin
        m_ovf = 0;
        m_cnt = 0;
      end
      if (!en) begin
        m_s1v = 0;
        m_s2v = 0;
      end else if (!stall) begin
        m_s2v = m_s1v;
        if (m_s1v) begin
          r      = round_ref(m_s1x, SH);
          m_last = clip_ref(r, OW);
          m_sat  = (m_last != r);
        end
        m_s1v = itr;
        if (itr) m_s1x = longint'($signed(in_data));
      end
    end
  end

  bit     collect = 0;
  longint got[$];
  always @(negedge clk) begin
    if (collect && out_valid && out_ready) got.push_back(longint'($signed(out_data)));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int x);
    int n  = 0;
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = IW'(x);
    do begin
      @(negedge clk);
      ok = in_ready;
      step();
      n++;
    end while (!ok && n < 50);
    chk("push accepted", ok, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  int cw2_exp[6] = '{0, 0, 1, 2, 3, 3};

  initial begin
    rst_n = 0; en = 0; in_valid = 0; in_data = '0; out_ready = 0; clr_ovf = 0;
    en1 = 0; in_valid1 = 0; in_data1 = '0; out_ready1 = 0; clr1 = 0;
    repeat (2) step();
    chk("reset out_data", $signed(out_data), 0);
    chk("reset sat_cnt", sat_cnt, 0);
    rst_n = 1; en = 1; out_ready = 1; en1 = 1; out_ready1 = 1;
    step();

    // Rounding: 5 -> 3, -5 -> -2, back to back.
    push(5);
    push(-5);
    @(negedge clk);
    chk("r5 valid", out_valid, 1);
    chk("r5 data", $signed(out_data), 3);
    step();
    @(negedge clk);
    chk("rm5 data", $signed(out_data), -2);
    chk("rm5 sat", out_sat, 0);
    step();

    // Positive clip and the most negative input that still fits.
    push(65535);
    push(-65536);
    @(negedge clk);
    chk("max data", $signed(out_data), 32767);
    chk("max sat", out_sat, 1);
    step();
    @(negedge clk);
    chk("min data", $signed(out_data), -32768);
    chk("min sat", out_sat, 0);
    chk("min ovf", ovf, 1);
    chk("min sat_cnt", sat_cnt, 1);
    repeat (2) step();

    // Stall: 1,3,5,7 with out_ready low for 3 cycles once output appears.
    collect = 1;
    fork
      begin
        push(1); push(3); push(5); push(7);
      end
      begin
        int n = 0;
        do begin step(); n++; end while (!out_valid && n < 20);
        out_ready = 0;
        repeat (3) step();
        out_ready = 1;
      end
    join
    repeat (6) step();
    collect = 0;
    chk("stall count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("stall order", got[i], i + 1);

    // SHIFT=0, CW=2 instance: saturating counter and clear-vs-event priority.
    in_data1 = IW'(40000); in_valid1 = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 3) in_valid1 = 0;
      @(negedge clk);
      chk("cw2 sat_cnt", sat_cnt1, cw2_exp[i]);
      if (i == 1) begin
        chk("cw2 data", $signed(out_data1), 32767);
        chk("cw2 sat", out_sat1, 1);
      end
    end
    in_valid1 = 1;
    step();
    in_valid1 = 0;
    step();
    clr1 = 1;
    step();
    clr1 = 0;
    @(negedge clk);
    chk("clr+event cnt", sat_cnt1, 1);
    chk("clr+event ovf", ovf1, 1);
    clr1 = 1;
    step();
    clr1 = 0;
    @(negedge clk);
    chk("clr cnt", sat_cnt1, 0);
    chk("clr ovf", ovf1, 0);
    in_data1 = IW'(-40000); in_valid1 = 1;
    step();
    in_valid1 = 0;
    step();
    @(negedge clk);
    chk("neg40000 data", $signed(out_data1), -32768);
    chk("neg40000 sat", out_sat1, 1);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int k;
      step();
      en        = ($urandom_range(0, 99) < 96);
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 75);
      clr_ovf   = ($urandom_range(0, 99) < 3);
      k         = $urandom_range(0, 99);
      in_data   = (k < 10) ? IW'(65535) : (k < 15) ? IW'(-65536) : IW'($urandom);
    end
    step();
    en = 1; in_valid = 0; out_ready = 1; clr_ovf = 0;
    repeat (3) step();

    // Flush with en: two stalled samples in flight are discarded.
    push(65535);
    repeat (3) step();
    out_ready = 0;
    push(11);
    push(13);
    en = 0;
    step();
    en = 1; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush no valid", out_valid, 0);
      step();
    end
    chk("flush ovf kept", ovf, 1);

    // Asynchronous reset mid-cycle with samples in flight.
    push(21);
    push(23);
    #1 rst_n = 0;
    #1;
    chk("arst out_valid", out_valid, 0);
    chk("arst out_data", $signed(out_data), 0);
    chk("arst out_sat", out_sat, 0);
    chk("arst ovf", ovf, 0);
    chk("arst sat_cnt", sat_cnt, 0);
    repeat (2) step();
    rst_n = 1;
    step();
    push(5);
    @(negedge clk);
    chk("post-rst early", out_valid, 0);
    step();
    @(negedge clk);
    chk("post-rst valid", out_valid, 1);
    chk("post-rst data", $signed(out_data), 3);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_sat.md
ROUND_SAT -- requirements
Module: round_sat

Interface
REQ-001 Parameter IW, default 17, input sample width (signed); matches the grown width out of the upstream adder stage.
REQ-002 Parameter SHIFT, default 1, number of LSBs removed by rounding; 0 = no rounding.
REQ-003 Parameter OW, default 16, output sample width (signed); legal range 2 <= OW <= IW-SHIFT.
REQ-004 Parameter CW, default 16, saturation event counter width.
REQ-005 clk  input  1  single clock; all state changes on posedge clk.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low; fixed decision.
REQ-007 en  input  1  stage enable; low flushes the pipeline.
REQ-008 in_data  input  IW  signed sample.
REQ-009 in_valid  input  1  in_data valid this cycle.
REQ-010 in_ready  output  1  stage accepts in_data this cycle.
REQ-011 out_data  output  OW  signed rounded, saturated sample.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 out_sat  output  1  current out_data was clipped; qualified by out_valid.
REQ-015 ovf  output  1  sticky flag; set on any saturated output transfer.
REQ-016 sat_cnt  output  CW  count of saturated output transfers.
REQ-017 clr_ovf  input  1  synchronous single-cycle clear of ovf and sat_cnt.

Function
REQ-018 Input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
REQ-019 Two-stage pipeline: S1 rounds, S2 saturates and drives out_data; latency exactly 2 cycles from input transfer to out_valid with no stall.
REQ-020 S1 rounding: round-half-up, r = (in_data + 2^(SHIFT-1)) >>> SHIFT, computed at IW+1 bits so it never wraps; SHIFT=0 passes in_data unchanged.
REQ-021 S2 saturation: r > 2^(OW-1)-1 -> out_data = 2^(OW-1)-1; r < -2^(OW-1) -> out_data = -2^(OW-1); else r truncated to OW bits; out_sat set when either clip occurs.
REQ-022 Stall = out_valid & ~out_ready; while stalled S1 and S2 hold data and valid bits unchanged.
REQ-023 in_ready = en & ~stall; combinational, no dependence on in_valid.
REQ-024 Without stall, S1 loads on input transfer and clears its valid otherwise; S2 takes S1 contents every cycle.
REQ-025 Full pipeline with out_ready high sustains one sample per cycle, no bubbles.
REQ-026 en low: in_ready = 0; S1 and S2 valid bits clear on the next posedge, in-flight samples discarded; ovf and sat_cnt retained.
REQ-027 out_data holds last value while out_valid low; out_data, out_sat stable while stalled.
REQ-028 sat_cnt increments by 1 per saturated output transfer; saturates at 2^CW-1, no wrap.
REQ-029 ovf set on the first saturated output transfer; remains set until clr_ovf.
REQ-030 clr_ovf in the same cycle as a saturated output transfer: sat_cnt = 1 and ovf = 1 afterwards (event wins over clear).

Reset
REQ-031 rst_n low asynchronously forces: S1/S2 valid = 0, out_valid = 0, out_data = 0, out_sat = 0, ovf = 0, sat_cnt = 0; in_ready follows REQ-023.
REQ-032 Reset mid-stream discards all in-flight samples; first output after release appears 2 cycles after the first post-reset input transfer.

Verification
REQ-033 Defaults, out_ready=1, in_data 5 then -5 on consecutive cycles -> out_data 3 then -2, two cycles later, out_sat=0.
REQ-034 Defaults, in_data 65535 -> out_data 32767, out_sat=1, ovf=1, sat_cnt=1; in_data -65536 -> out_data -32768, out_sat=0.
REQ-035 SHIFT=0, OW=16, in_data -40000 -> out_data -32768, out_sat=1.
REQ-036 Stream 1,3,5,7 with out_ready low for 3 cycles after first out_valid -> no sample lost or duplicated, in_ready low while stalled, order preserved.
REQ-037 CW=2, four saturated transfers -> sat_cnt 1,2,3,3; clr_ovf with a fifth saturated transfer -> sat_cnt=1, ovf=1.
REQ-038 Two samples in flight, drop en for one cycle, then rst_n low mid-cycle -> no out_valid from discarded samples; all outputs 0 immediately on rst_n assertion.
